// File: rtl/rx_flex_deser.sv
// rx_flex_deser: USB RX serial-to-parallel deserializer with a held-word valid/ack handshake,
// sticky overflow and synchronous clear. Define RX_DESER_FLUSH_EN to let flush push out a partial word.
module rx_flex_deser #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 0,
  parameter int CNT_W     = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                serial_in,
  input  logic                shift_enable,
  input  logic                clear,
  input  logic                flush,
  input  logic                word_ack,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                word_valid,
  output logic [CNT_W-1:0]    valid_bits,
  output logic                overflow,
  output logic [CNT_W-1:0]    bit_count
);

  localparam logic [NUM_BITS-1:0] ONES = '1;
  localparam logic [CNT_W-1:0]    LAST = CNT_W'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_q, sr_d, po_q, po_d, shifted, cand_sr;
  logic [CNT_W-1:0]    cnt_q, cnt_d, vb_q, vb_d, cand_cnt;
  logic                wv_q, wv_d, ov_q, ov_d, word_done;

  generate
    if (SHIFT_MSB != 0) begin : g_msb_first
      assign shifted = {sr_q[NUM_BITS-2:0], serial_in};
    end else begin : g_lsb_first
      assign shifted = {serial_in, sr_q[NUM_BITS-1:1]};
    end
  endgenerate

`ifndef RX_DESER_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_comb begin
    cand_sr   = shift_enable ? shifted : sr_q;
    cand_cnt  = shift_enable ? cnt_q + 1'b1 : cnt_q;
    word_done = shift_enable && (cnt_q == LAST);
`ifdef RX_DESER_FLUSH_EN
    // A bit shifted on the flush edge is counted first, so it travels with the partial word.
    if (flush && (cand_cnt != '0)) word_done = 1'b1;
`endif

    sr_d  = cand_sr;
    cnt_d = cand_cnt;
    po_d  = po_q;
    vb_d  = vb_q;
    wv_d  = wv_q & ~word_ack;
    ov_d  = ov_q;

    if (clear) begin
      sr_d  = ONES;
      cnt_d = '0;
      ov_d  = 1'b0;
    end else if (word_done) begin
      sr_d  = ONES;
      cnt_d = '0;
      // The held word wins unless it leaves on this same edge.
      if (wv_q && !word_ack) begin
        ov_d = 1'b1;
      end else begin
        po_d = cand_sr;
        vb_d = cand_cnt;
        wv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q  <= ONES;
      cnt_q <= '0;
      po_q  <= ONES;
      vb_q  <= '0;
      wv_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      po_q  <= po_d;
      vb_q  <= vb_d;
      wv_q  <= wv_d;
      ov_q  <= ov_d;
    end
  end

  assign parallel_out = po_q;
  assign word_valid   = wv_q;
  assign valid_bits   = vb_q;
  assign overflow     = ov_q;
  assign bit_count    = cnt_q;

endmodule

// File: tb/tb_rx_flex_deser.sv
// Bench for rx_flex_deser: LSB-first and MSB-first instances share stimulus and are checked
// every cycle against a bit-queue model, plus literal expectations for the directed cases.
module tb_rx_flex_deser;

  localparam int N = 8;

  logic clk = 1'b0;
  logic n_rst, serial_in, shift_enable, clear, flush, word_ack;

  logic [N-1:0] po_l, po_m;
  logic         wv_l, wv_m, ov_l, ov_m;
  logic [3:0]   vb_l, vb_m, bc_l, bc_m;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model state
  bit           q[$];
  logic [N-1:0] m_po_l, m_po_m;
  logic         m_wv, m_ov;
  int           m_vb;

  always #5 clk = ~clk;

  rx_flex_deser #(.NUM_BITS(N), .SHIFT_MSB(0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .clear(clear), .flush(flush), .word_ack(word_ack),
    .parallel_out(po_l), .word_valid(wv_l), .valid_bits(vb_l), .overflow(ov_l), .bit_count(bc_l));

  rx_flex_deser #(.NUM_BITS(N), .SHIFT_MSB(1)) u_msb (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .clear(clear), .flush(flush), .word_ack(word_ack),
    .parallel_out(po_m), .word_valid(wv_m), .valid_bits(vb_m), .overflow(ov_m), .bit_count(bc_m));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Received bits in arrival order placed into a word of ones.
  function automatic logic [N-1:0] assemble(input bit msb_first);
    logic [N-1:0] w;
    int k;
    w = '1;
    k = q.size();
    for (int j = 0; j < k; j++) begin
      if (msb_first) w[k-1-j] = q[j];
      else           w[N-k+j] = q[j];
    end
    return w;
  endfunction

  task automatic model_step(input bit se, input bit si, input bit clr, input bit fl, input bit ack);
    bit take, done;
    take = m_wv && ack;
    if (clr) begin
      q.delete();
      m_ov = 1'b0;
      if (take) m_wv = 1'b0;
    end else begin
      if (se) q.push_back(si);
      done = (q.size() == N);
`ifdef RX_DESER_FLUSH_EN
      if (fl && q.size() > 0) done = 1'b1;
`else
      if (fl) done = done;
`endif
      if (done) begin
        if (m_wv && !ack) begin
          m_ov = 1'b1;
        end else begin
          m_po_l = assemble(1'b0);
          m_po_m = assemble(1'b1);
          m_vb   = q.size();
          m_wv   = 1'b1;
        end
        q.delete();
      end else if (take) begin
        m_wv = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit se, input bit si, input bit clr, input bit fl, input bit ack);
    shift_enable = se;
    serial_in    = si;
    clear        = clr;
    flush        = fl;
    word_ack     = ack;
    @(posedge clk);
    model_step(se, si, clr, fl, ack);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_last);
    for (int i = 0; i < 8; i++) cyc(1'b1, b[i], 1'b0, 1'b0, (i == 7) ? ack_last : 1'b0);
  endtask

  task automatic idle_ack();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("po_lsb", 32'(po_l), 32'(m_po_l));
      chk("po_msb", 32'(po_m), 32'(m_po_m));
      chk("wv_lsb", 32'(wv_l), 32'(m_wv));
      chk("wv_msb", 32'(wv_m), 32'(m_wv));
      chk("vb_lsb", 32'(vb_l), 32'(m_vb));
      chk("vb_msb", 32'(vb_m), 32'(m_vb));
      chk("ov_lsb", 32'(ov_l), 32'(m_ov));
      chk("ov_msb", 32'(ov_m), 32'(m_ov));
      chk("bc_lsb", 32'(bc_l), 32'(q.size()));
      chk("bc_msb", 32'(bc_m), 32'(q.size()));
    end
  end

  initial begin
    n_rst = 1'b0; serial_in = 1'b0; shift_enable = 1'b0;
    clear = 1'b0; flush = 1'b0; word_ack = 1'b0;
    m_po_l = '1; m_po_m = '1; m_wv = 1'b0; m_ov = 1'b0; m_vb = 0;
    repeat (2) @(negedge clk);
    chk("rst_po", 32'(po_l), 32'hFF);
    chk("rst_wv", 32'(wv_l), 32'h0);
    chk("rst_vb", 32'(vb_m), 32'h0);
    chk("rst_ov", 32'(ov_l), 32'h0);
    chk("rst_bc", 32'(bc_l), 32'h0);
    n_rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // 1/2: A5 stream, then 0x01 stream
    send_byte(8'hA5, 1'b0);
    @(negedge clk);
    chk("t1_po_lsb", 32'(po_l), 32'hA5);
    chk("t1_po_msb", 32'(po_m), 32'hA5);
    chk("t1_wv", 32'(wv_l), 32'h1);
    chk("t1_vb", 32'(vb_l), 32'h8);
    chk("t1_bc", 32'(bc_l), 32'h0);
    chk("t1_model", 32'(m_po_l), 32'hA5);
    #1; idle_ack();
    @(negedge clk); chk("t1_ack_wv", 32'(wv_l), 32'h0);
    #1; send_byte(8'h01, 1'b0);
    @(negedge clk);
    chk("t2_po_lsb", 32'(po_l), 32'h01);
    chk("t2_po_msb", 32'(po_m), 32'h80);
    chk("t2_model_msb", 32'(m_po_m), 32'h80);
    #1; idle_ack();

    // 3: overflow and clear
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    @(negedge clk);
    chk("t3_po", 32'(po_l), 32'h3C);
    chk("t3_ov", 32'(ov_l), 32'h1);
    #1; cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_clr_ov", 32'(ov_m), 32'h0);
    chk("t3_clr_wv", 32'(wv_m), 32'h1);

    // 4: ack on the completing edge
    #1; send_byte(8'h5A, 1'b1);
    @(negedge clk);
    chk("t4_po", 32'(po_l), 32'h5A);
    chk("t4_wv", 32'(wv_l), 32'h1);
    chk("t4_ov", 32'(ov_l), 32'h0);
    #1; idle_ack();

    // 5: clear beats shift_enable
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_bc", 32'(bc_l), 32'h0);
    chk("t5_wv", 32'(wv_l), 32'h0);

    // 6: flush after bits 1,1,0
    #1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
`ifdef RX_DESER_FLUSH_EN
    chk("t6_wv", 32'(wv_l), 32'h1);
    chk("t6_vb", 32'(vb_l), 32'h3);
    chk("t6_po", 32'(po_l), 32'h7F);
`else
    chk("t6_wv", 32'(wv_l), 32'h0);
    chk("t6_bc", 32'(bc_l), 32'h3);
`endif
    #1; cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(99) < 75, 1'($urandom), $urandom_range(99) < 3,
          $urandom_range(99) < 6, $urandom_range(99) < 30);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
